// File: rtl/jtframe_ba0_arb.sv
// SDRAM bank 0 arbiter: shares the read/write bank between three cs/ok requesters.
// A watchdog stops a lost controller reply from hanging a requester.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | no access; pick a winner among requesters with cs high
// ST_REQ  | ba0_rd/ba0_wr asserted, waiting for ba0_ack (or early ba0_rdy)
// ST_WAIT | request accepted, waiting for ba0_dok/ba0_rdy
// ST_DONE | one-cycle bubble so the winner can drop cs
module jtframe_ba0_arb #(
  parameter int         SDRAMW = 23,
  parameter bit         RR     = 1'b1,
  parameter logic [7:0] TOUT   = 8'd255
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              req0_cs,
  input  logic              req0_wr,
  input  logic [SDRAMW-1:0] req0_addr,
  input  logic [15:0]       req0_din,
  input  logic [1:0]        req0_din_m,
  output logic              req0_ok,
  output logic [15:0]       req0_dout,

  input  logic              req1_cs,
  input  logic              req1_wr,
  input  logic [SDRAMW-1:0] req1_addr,
  input  logic [15:0]       req1_din,
  input  logic [1:0]        req1_din_m,
  output logic              req1_ok,
  output logic [15:0]       req1_dout,

  input  logic              req2_cs,
  input  logic              req2_wr,
  input  logic [SDRAMW-1:0] req2_addr,
  input  logic [15:0]       req2_din,
  input  logic [1:0]        req2_din_m,
  output logic              req2_ok,
  output logic [15:0]       req2_dout,

  output logic [SDRAMW-1:0] ba0_addr,
  output logic              ba0_rd,
  output logic              ba0_wr,
  output logic [15:0]       ba0_din,
  output logic [1:0]        ba0_din_m,
  input  logic              ba0_ack,
  input  logic              ba0_dok,
  input  logic              ba0_rdy,
  input  logic [15:0]       sdram_dout,

  output logic              busy,
  output logic              tout_err
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DONE} state_t;

  state_t            state;
  logic [1:0]        win_q;
  logic              wr_q;
  logic [1:0]        rr_ptr;
  logic [7:0]        wdog;
  logic [2:0]        ok_q;
  logic [15:0]       dout_q [3];

  logic [2:0]        cs_v, wr_v;
  logic [SDRAMW-1:0] addr_v [3];
  logic [15:0]       din_v  [3];
  logic [1:0]        mask_v [3];

  logic [1:0]        start, cand, win;
  logic [2:0]        cand_sum;
  logic              found;
  logic              wd_hit;

  assign cs_v      = {req2_cs, req1_cs, req0_cs};
  assign wr_v      = {req2_wr, req1_wr, req0_wr};
  assign addr_v[0] = req0_addr;
  assign addr_v[1] = req1_addr;
  assign addr_v[2] = req2_addr;
  assign din_v[0]  = req0_din;
  assign din_v[1]  = req1_din;
  assign din_v[2]  = req2_din;
  assign mask_v[0] = req0_din_m;
  assign mask_v[1] = req1_din_m;
  assign mask_v[2] = req2_din_m;

  assign req0_ok   = ok_q[0];
  assign req1_ok   = ok_q[1];
  assign req2_ok   = ok_q[2];
  assign req0_dout = dout_q[0];
  assign req1_dout = dout_q[1];
  assign req2_dout = dout_q[2];

  assign busy   = (state != ST_IDLE);
  assign wd_hit = (wdog == TOUT);

  // rr_ptr holds where the next search starts; fixed priority always starts at 0
  always_comb begin
    start    = RR ? rr_ptr : 2'd0;
    found    = 1'b0;
    win      = 2'd0;
    cand_sum = 3'd0;
    cand     = 2'd0;
    for (int i = 0; i < 3; i++) begin
      cand_sum = {1'b0, start} + 3'(i);
      cand     = (cand_sum >= 3'd3) ? 2'(cand_sum - 3'd3) : cand_sum[1:0];
      if (!found && cs_v[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      win_q     <= 2'd0;
      wr_q      <= 1'b0;
      rr_ptr    <= 2'd0;
      wdog      <= 8'd0;
      ok_q      <= 3'd0;
      dout_q[0] <= 16'd0;
      dout_q[1] <= 16'd0;
      dout_q[2] <= 16'd0;
      ba0_addr  <= '0;
      ba0_rd    <= 1'b0;
      ba0_wr    <= 1'b0;
      ba0_din   <= 16'd0;
      ba0_din_m <= 2'd0;
      tout_err  <= 1'b0;
    end else begin
      ok_q <= 3'd0;
      case (state)
        ST_IDLE: begin
          wdog <= 8'd0;
          if (found) begin
            win_q     <= win;
            wr_q      <= wr_v[win];
            ba0_addr  <= addr_v[win];
            ba0_din   <= din_v[win];
            ba0_din_m <= mask_v[win];
            ba0_rd    <= ~wr_v[win];
            ba0_wr    <= wr_v[win];
            if (RR) rr_ptr <= (win == 2'd2) ? 2'd0 : win + 2'd1;
            state     <= ST_REQ;
          end
        end
        ST_REQ: begin
          wdog <= wdog + 8'd1;
          if (ba0_rdy) begin
            // controller skipped the ack: treat as ack and completion together
            ba0_rd      <= 1'b0;
            ba0_wr      <= 1'b0;
            if (ba0_dok && !wr_q) dout_q[win_q] <= sdram_dout;
            ok_q[win_q] <= 1'b1;
            state       <= ST_DONE;
          end else if (wd_hit) begin
            ba0_rd      <= 1'b0;
            ba0_wr      <= 1'b0;
            ok_q[win_q] <= 1'b1;
            tout_err    <= 1'b1;
            state       <= ST_DONE;
          end else if (ba0_ack) begin
            ba0_rd <= 1'b0;
            ba0_wr <= 1'b0;
            state  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          wdog <= wdog + 8'd1;
          if (ba0_rdy) begin
            if (ba0_dok && !wr_q) dout_q[win_q] <= sdram_dout;
            ok_q[win_q] <= 1'b1;
            state       <= ST_DONE;
          end else if (wd_hit) begin
            ok_q[win_q] <= 1'b1;
            tout_err    <= 1'b1;
            state       <= ST_DONE;
          end else if (ba0_dok && !wr_q) begin
            dout_q[win_q] <= sdram_dout;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtframe_ba0_arb.sv
// Bench for jtframe_ba0_arb: a round-robin and a fixed-priority instance share
// one stimulus stream and are checked against a transaction-level model.
module tb_jtframe_ba0_arb;
  localparam int AW = 23;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]    cs;
  logic [2:0]    wr;
  logic [AW-1:0] addr  [3];
  logic [15:0]   din   [3];
  logic [1:0]    dmask [3];
  logic          ba0_ack, ba0_dok, ba0_rdy;
  logic [15:0]   sdram_dout;

  logic [2:0]    a_ok, b_ok;
  logic [15:0]   a_dout [3];
  logic [15:0]   b_dout [3];
  logic [AW-1:0] a_addr, b_addr;
  logic          a_rd, a_wr, b_rd, b_wr;
  logic [15:0]   a_din, b_din;
  logic [1:0]    a_dm, b_dm;
  logic          a_busy, b_busy, a_terr, b_terr;

  jtframe_ba0_arb #(.SDRAMW(AW), .RR(1'b1), .TOUT(8'd255)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .req0_cs(cs[0]), .req0_wr(wr[0]), .req0_addr(addr[0]), .req0_din(din[0]),
    .req0_din_m(dmask[0]), .req0_ok(a_ok[0]), .req0_dout(a_dout[0]),
    .req1_cs(cs[1]), .req1_wr(wr[1]), .req1_addr(addr[1]), .req1_din(din[1]),
    .req1_din_m(dmask[1]), .req1_ok(a_ok[1]), .req1_dout(a_dout[1]),
    .req2_cs(cs[2]), .req2_wr(wr[2]), .req2_addr(addr[2]), .req2_din(din[2]),
    .req2_din_m(dmask[2]), .req2_ok(a_ok[2]), .req2_dout(a_dout[2]),
    .ba0_addr(a_addr), .ba0_rd(a_rd), .ba0_wr(a_wr), .ba0_din(a_din), .ba0_din_m(a_dm),
    .ba0_ack(ba0_ack), .ba0_dok(ba0_dok), .ba0_rdy(ba0_rdy), .sdram_dout(sdram_dout),
    .busy(a_busy), .tout_err(a_terr)
  );

  jtframe_ba0_arb #(.SDRAMW(AW), .RR(1'b0), .TOUT(8'd255)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_cs(cs[0]), .req0_wr(wr[0]), .req0_addr(addr[0]), .req0_din(din[0]),
    .req0_din_m(dmask[0]), .req0_ok(b_ok[0]), .req0_dout(b_dout[0]),
    .req1_cs(cs[1]), .req1_wr(wr[1]), .req1_addr(addr[1]), .req1_din(din[1]),
    .req1_din_m(dmask[1]), .req1_ok(b_ok[1]), .req1_dout(b_dout[1]),
    .req2_cs(cs[2]), .req2_wr(wr[2]), .req2_addr(addr[2]), .req2_din(din[2]),
    .req2_din_m(dmask[2]), .req2_ok(b_ok[2]), .req2_dout(b_dout[2]),
    .ba0_addr(b_addr), .ba0_rd(b_rd), .ba0_wr(b_wr), .ba0_din(b_din), .ba0_din_m(b_dm),
    .ba0_ack(ba0_ack), .ba0_dok(ba0_dok), .ba0_rdy(ba0_rdy), .sdram_dout(sdram_dout),
    .busy(b_busy), .tout_err(b_terr)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  int          ptr_a = 0;
  int          wa, wb;
  logic [15:0] m_dout_a [3];
  logic [15:0] m_dout_b [3];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input logic [2:0] c, input int start);
    for (int i = 0; i < 3; i++) begin
      int k;
      k = (start + i) % 3;
      if (c[k]) return k;
    end
    return 0;
  endfunction

  task automatic scramble();
    for (int i = 0; i < 3; i++) begin
      addr[i]  = AW'($urandom);
      din[i]   = 16'($urandom);
      dmask[i] = 2'($urandom);
      wr[i]    = 1'($urandom);
    end
  endtask

  task automatic chk_douts(input string tag);
    chk({tag, "_dout_rr"}, {a_dout[2], a_dout[1], a_dout[0]}, {m_dout_a[2], m_dout_a[1], m_dout_a[0]});
    chk({tag, "_dout_fp"}, {b_dout[2], b_dout[1], b_dout[0]}, {m_dout_b[2], m_dout_b[1], m_dout_b[0]});
  endtask

  // One complete access starting from IDLE with cs = c.
  task automatic access(input logic [2:0] c, input int ack_dly, input int rdy_dly,
                        input bit skip_ack, input bit dok_sep, input bit drop_mid,
                        input logic [15:0] rdata, input string tag);
    logic [AW-1:0] ga, gb;
    logic [15:0]   da, db;
    logic [1:0]    ma, mb;
    logic          ra, rb;
    cs = c;
    wa = pick(c, ptr_a);
    wb = pick(c, 0);
    ptr_a = (wa + 1) % 3;
    ga = addr[wa]; da = din[wa]; ma = dmask[wa]; ra = wr[wa];
    gb = addr[wb]; db = din[wb]; mb = dmask[wb]; rb = wr[wb];
    tick();
    scramble();
    if (drop_mid) cs = 3'b000;
    for (int i = 0; i <= ack_dly; i++) begin
      chk({tag, "_req_rr"}, {a_busy, a_rd, a_wr, a_addr, a_din, a_dm}, {1'b1, ~ra, ra, ga, da, ma});
      chk({tag, "_req_fp"}, {b_busy, b_rd, b_wr, b_addr, b_din, b_dm}, {1'b1, ~rb, rb, gb, db, mb});
      if (i < ack_dly) tick();
    end
    if (!skip_ack) begin
      ba0_ack = 1'b1;
      tick();
      ba0_ack = 1'b0;
      chk({tag, "_rdwr_drop"}, {a_rd, a_wr, b_rd, b_wr}, 4'b0000);
      repeat (rdy_dly) tick();
      sdram_dout = rdata;
      ba0_dok = 1'b1;
      if (dok_sep) begin
        tick();
        ba0_dok = 1'b0;
        sdram_dout = 16'($urandom);
        chk({tag, "_no_early_ok"}, {a_ok, b_ok}, 6'd0);
      end
      ba0_rdy = 1'b1;
      tick();
      ba0_dok = 1'b0;
      ba0_rdy = 1'b0;
      sdram_dout = 16'($urandom);
      if (!ra) m_dout_a[wa] = rdata;
      if (!rb) m_dout_b[wb] = rdata;
    end else begin
      ba0_rdy = 1'b1;
      tick();
      ba0_rdy = 1'b0;
    end
    chk({tag, "_ok_rr"}, a_ok, 3'b001 << wa);
    chk({tag, "_ok_fp"}, b_ok, 3'b001 << wb);
    chk({tag, "_done"}, {a_busy, b_busy, a_rd, a_wr, b_rd, b_wr}, 6'b110000);
    chk_douts(tag);
    tick();
    chk({tag, "_idle"}, {a_ok, b_ok, a_busy, b_busy}, 8'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int n;
    cs = 3'b000; wr = 3'b000;
    ba0_ack = 1'b0; ba0_dok = 1'b0; ba0_rdy = 1'b0; sdram_dout = 16'd0;
    for (int i = 0; i < 3; i++) begin
      addr[i] = '0; din[i] = 16'd0; dmask[i] = 2'd0;
      m_dout_a[i] = 16'd0; m_dout_b[i] = 16'd0;
    end

    // reset state
    repeat (3) tick();
    chk("reset_rr", {a_ok, a_rd, a_wr, a_addr, a_din, a_dm, a_busy, a_terr}, 64'd0);
    chk("reset_fp", {b_ok, b_rd, b_wr, b_addr, b_din, b_dm, b_busy, b_terr}, 64'd0);
    chk_douts("reset");
    rst_n = 1'b1;
    tick();

    // all requesters held high: rr grants 0,1,2,0,1,2 and fixed grants 0 each time
    scramble();
    for (int i = 0; i < 6; i++) access(3'b111, 1, 1, 1'b0, 1'b0, 1'b0, 16'($urandom), "rr_all");
    cs = 3'b000;

    // single read from req0
    wr[0] = 1'b0; addr[0] = 23'h000100;
    access(3'b001, 2, 4, 1'b0, 1'b0, 1'b0, 16'hBEEF, "read0");
    chk("read0_value", a_dout[0], 16'hBEEF);
    cs = 3'b000;

    // masked write from req1 at the top address; dok must not touch dout
    wr[1] = 1'b1; addr[1] = 23'h7FFFFF; din[1] = 16'h1234; dmask[1] = 2'b01;
    access(3'b010, 3, 1, 1'b0, 1'b0, 1'b0, 16'hDEAD, "write1");
    cs = 3'b000;

    // rdy arriving in REQ without any ack
    wr[2] = 1'b0;
    access(3'b100, 1, 0, 1'b1, 1'b0, 1'b0, 16'hCAFE, "rdy_in_req");
    // dok ahead of rdy, requester dropping cs mid-access
    wr[0] = 1'b0;
    access(3'b101, 0, 2, 1'b0, 1'b1, 1'b1, 16'h5A5A, "dok_sep");

    // watchdog: controller never answers
    chk("terr_before", {a_terr, b_terr}, 2'b00);
    wr[0] = 1'b0;
    cs = 3'b001;
    wa = pick(cs, ptr_a);
    wb = 0;
    ptr_a = (wa + 1) % 3;
    tick();
    n = 0;
    while (n < 300 && a_ok == 3'd0) begin
      tick();
      n++;
    end
    chk("wd_latency", n, 256);
    chk("wd_ok", {a_ok, b_ok}, {3'b001 << wa, 3'b001 << wb});
    chk("wd_terr", {a_terr, b_terr, a_rd, a_wr, b_rd, b_wr}, 6'b110000);
    chk_douts("wd");
    // late controller pulses in DONE and IDLE are ignored
    cs = 3'b000;
    ba0_ack = 1'b1; ba0_dok = 1'b1; ba0_rdy = 1'b1; sdram_dout = 16'hF00D;
    tick();
    tick();
    ba0_ack = 1'b0; ba0_dok = 1'b0; ba0_rdy = 1'b0;
    chk("wd_late", {a_ok, b_ok, a_busy, b_busy}, 8'd0);
    chk_douts("wd_late");
    wr[2] = 1'b0;
    access(3'b100, 1, 1, 1'b0, 1'b0, 1'b0, 16'h0F0F, "after_wd");
    chk("terr_sticky", {a_terr, b_terr}, 2'b11);

    // randomized accesses
    for (int it = 0; it < 40; it++) begin
      scramble();
      access(3'($urandom_range(1, 7)), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3) == 0, 1'($urandom), $urandom_range(0, 3) == 0,
             16'($urandom), "rnd");
    end

    // reset in the middle of an access
    cs = 3'b010;
    wr[1] = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid", {a_rd, a_wr, b_rd, b_wr, a_ok, b_ok, a_busy, b_busy, a_terr, b_terr}, 16'd0);
    cs = 3'b000;
    ptr_a = 0;
    for (int i = 0; i < 3; i++) begin
      m_dout_a[i] = 16'd0;
      m_dout_b[i] = 16'd0;
    end
    chk_douts("rst_mid");
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_release", {a_busy, b_busy}, 2'b00);
    scramble();
    access(3'b111, 0, 0, 1'b0, 1'b0, 1'b0, 16'h1357, "rst_ptr");
    access(3'b111, 0, 0, 1'b0, 1'b0, 1'b0, 16'h2468, "rst_ptr2");
    cs = 3'b000;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
